axi_rd_4_splitter: RTL and testbench



---
 rtl/axi_rd_4_splitter.sv | 212 +++++++++++++++++++++
 tb/tb_axi_rd_4_splitter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_4_splitter.sv
// -----------------------------------------------------------------------------
// axi_rd_4_splitter
//
// Routes one AXI read initiator to four read targets (a..d). The target is
// chosen by araddr[SEL_LSB+1:SEL_LSB] (0=a, 1=b, 2=c, 3=d). Read data is
// returned upstream strictly in AR-acceptance order. An order FIFO holds the
// target index of every outstanding burst; its head selects which target may
// present R beats upstream.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   ar* / arvalid / arready         upstream AR channel
//   r*  / rvalid  / rready          upstream R channel
//   x_ar* / x_arvalid / x_arready   AR channel to target x (x = a..d)
//   x_r*  / x_rvalid  / x_rready    R channel from target x (x = a..d)
// -----------------------------------------------------------------------------
module axi_rd_4_splitter #(
    parameter int IDWID   = 4,
    parameter int DWID    = 64,
    parameter int EXTRAS  = 8,
    parameter int DEPTH   = 8,
    parameter int SEL_LSB = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    // upstream AR
    input  logic [IDWID-1:0]  arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [EXTRAS-1:0] arextras,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    // upstream R
    output logic [IDWID-1:0]  rid,
    output logic [DWID-1:0]   rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    // target a
    output logic [IDWID-1:0]  a_arid,
    output logic [31:0]       a_araddr,
    output logic [7:0]        a_arlen,
    output logic [EXTRAS-1:0] a_arextras,
    output logic [1:0]        a_arburst,
    output logic              a_arvalid,
    input  logic              a_arready,
    input  logic [IDWID-1:0]  a_rid,
    input  logic [DWID-1:0]   a_rdata,
    input  logic [1:0]        a_rresp,
    input  logic              a_rlast,
    input  logic              a_rvalid,
    output logic              a_rready,
    // target b
    output logic [IDWID-1:0]  b_arid,
    output logic [31:0]       b_araddr,
    output logic [7:0]        b_arlen,
    output logic [EXTRAS-1:0] b_arextras,
    output logic [1:0]        b_arburst,
    output logic              b_arvalid,
    input  logic              b_arready,
    input  logic [IDWID-1:0]  b_rid,
    input  logic [DWID-1:0]   b_rdata,
    input  logic [1:0]        b_rresp,
    input  logic              b_rlast,
    input  logic              b_rvalid,
    output logic              b_rready,
    // target c
    output logic [IDWID-1:0]  c_arid,
    output logic [31:0]       c_araddr,
    output logic [7:0]        c_arlen,
    output logic [EXTRAS-1:0] c_arextras,
    output logic [1:0]        c_arburst,
    output logic              c_arvalid,
    input  logic              c_arready,
    input  logic [IDWID-1:0]  c_rid,
    input  logic [DWID-1:0]   c_rdata,
    input  logic [1:0]        c_rresp,
    input  logic              c_rlast,
    input  logic              c_rvalid,
    output logic              c_rready,
    // target d
    output logic [IDWID-1:0]  d_arid,
    output logic [31:0]       d_araddr,
    output logic [7:0]        d_arlen,
    output logic [EXTRAS-1:0] d_arextras,
    output logic [1:0]        d_arburst,
    output logic              d_arvalid,
    input  logic              d_arready,
    input  logic [IDWID-1:0]  d_rid,
    input  logic [DWID-1:0]   d_rdata,
    input  logic [1:0]        d_rresp,
    input  logic              d_rlast,
    input  logic              d_rvalid,
    output logic              d_rready
);

    localparam int PW = $clog2(DEPTH);

    // Order FIFO: one 2-bit target index per outstanding burst.
    logic [1:0]    order_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          order_empty;
    logic          order_full;
    logic          push;
    logic          pop;

    logic [1:0] sel;
    logic [1:0] head;
    logic [3:0] ar_vld_vec;
    logic [3:0] r_rdy_vec;

    // Per-target inputs gathered into index-able form.
    logic [3:0]       t_arready;
    logic [3:0]       t_rvalid;
    logic [IDWID-1:0] t_rid   [4];
    logic [DWID-1:0]  t_rdata [4];
    logic [1:0]       t_rresp [4];
    logic [3:0]       t_rlast;

    assign t_arready = {d_arready, c_arready, b_arready, a_arready};
    assign t_rvalid  = {d_rvalid,  c_rvalid,  b_rvalid,  a_rvalid};
    assign t_rlast   = {d_rlast,   c_rlast,   b_rlast,   a_rlast};
    assign t_rid     = '{a_rid,   b_rid,   c_rid,   d_rid};
    assign t_rdata   = '{a_rdata, b_rdata, c_rdata, d_rdata};
    assign t_rresp   = '{a_rresp, b_rresp, c_rresp, d_rresp};

    // AR payload is broadcast; only arvalid is steered.
    assign a_arid = arid;  assign a_araddr = araddr;  assign a_arlen = arlen;
    assign b_arid = arid;  assign b_araddr = araddr;  assign b_arlen = arlen;
    assign c_arid = arid;  assign c_araddr = araddr;  assign c_arlen = arlen;
    assign d_arid = arid;  assign d_araddr = araddr;  assign d_arlen = arlen;
    assign a_arextras = arextras;  assign a_arburst = arburst;
    assign b_arextras = arextras;  assign b_arburst = arburst;
    assign c_arextras = arextras;  assign c_arburst = arburst;
    assign d_arextras = arextras;  assign d_arburst = arburst;

    assign {d_arvalid, c_arvalid, b_arvalid, a_arvalid} = ar_vld_vec;
    assign {d_rready,  c_rready,  b_rready,  a_rready}  = r_rdy_vec;

    assign sel         = araddr[SEL_LSB+1:SEL_LSB];
    assign head        = order_mem[rd_ptr];
    assign order_empty = (count == '0);
    assign order_full  = (count == (PW+1)'(DEPTH));

    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        ar_vld_vec = '0;
        r_rdy_vec  = '0;
        rid        = '0;
        rdata      = '0;
        rresp      = '0;
        rlast      = 1'b0;

        // A full FIFO blocks acceptance even if a pop lands this cycle.
        arready = t_arready[sel] && !order_full;
        if (arvalid && !order_full) begin
            ar_vld_vec[sel] = 1'b1;
        end

        // Only the head target may talk upstream; others stall in place.
        rvalid = !order_empty && t_rvalid[head];
        if (!order_empty) begin
            r_rdy_vec[head] = rready;
        end
        if (rvalid) begin
            rid   = t_rid[head];
            rdata = t_rdata[head];
            rresp = t_rresp[head];
            rlast = t_rlast[head];
        end
    end

    assign push = arvalid && arready;
    assign pop  = rvalid && rready && rlast;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is not reset; entries are only read when the
    // count marks them valid, so clearing the pointers is enough.
    always_ff @(posedge clk) begin
        if (push) begin
            order_mem[wr_ptr] <= sel;
        end
    end

    a_no_push_full:  assert property (@(posedge clk) disable iff (!rst_n) !(push && order_full));
    a_no_pop_empty:  assert property (@(posedge clk) disable iff (!rst_n) !(pop && order_empty));
    a_onehot_arv:    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ar_vld_vec));
    a_onehot_rready: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_rdy_vec));

endmodule

// File: tb/tb_axi_rd_4_splitter.sv
// -----------------------------------------------------------------------------
// tb_axi_rd_4_splitter
//
// Randomised bench for axi_rd_4_splitter. Four behavioural targets accept
// whatever AR the DUT routes to them and answer with beats whose data encodes
// the answering target, ID, address and beat number. The reference model is
// a queue of expected upstream beats built in AR-acceptance order from the
// address decode, plus a queue of outstanding target indices used to predict
// arready, x_arvalid, x_rready and rvalid every cycle.
// -----------------------------------------------------------------------------
module tb_axi_rd_4_splitter;

    localparam int IDWID  = 4;
    localparam int DWID   = 64;
    localparam int EXTRAS = 8;
    localparam int DEPTH  = 8;
    localparam int RW     = IDWID + DWID + 2 + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [IDWID-1:0]  arid = '0;
    logic [31:0]       araddr = '0;
    logic [7:0]        arlen = '0;
    logic [EXTRAS-1:0] arextras = '0;
    logic [1:0]        arburst = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [IDWID-1:0]  rid;
    logic [DWID-1:0]   rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready = 1'b0;

    logic [IDWID-1:0]  t_arid     [4];
    logic [31:0]       t_araddr   [4];
    logic [7:0]        t_arlen    [4];
    logic [EXTRAS-1:0] t_arextras [4];
    logic [1:0]        t_arburst  [4];
    logic              t_arvalid  [4];
    logic              t_arready  [4];
    logic [IDWID-1:0]  t_rid      [4];
    logic [DWID-1:0]   t_rdata    [4];
    logic [1:0]        t_rresp    [4];
    logic              t_rlast    [4];
    logic              t_rvalid   [4];
    logic              t_rready   [4];

    axi_rd_4_splitter #(.IDWID(IDWID), .DWID(DWID), .EXTRAS(EXTRAS), .DEPTH(DEPTH), .SEL_LSB(30)) dut (
        .clk(clk), .rst_n(rst_n),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arextras(arextras), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .a_arid(t_arid[0]), .a_araddr(t_araddr[0]), .a_arlen(t_arlen[0]), .a_arextras(t_arextras[0]),
        .a_arburst(t_arburst[0]), .a_arvalid(t_arvalid[0]), .a_arready(t_arready[0]),
        .a_rid(t_rid[0]), .a_rdata(t_rdata[0]), .a_rresp(t_rresp[0]), .a_rlast(t_rlast[0]),
        .a_rvalid(t_rvalid[0]), .a_rready(t_rready[0]),
        .b_arid(t_arid[1]), .b_araddr(t_araddr[1]), .b_arlen(t_arlen[1]), .b_arextras(t_arextras[1]),
        .b_arburst(t_arburst[1]), .b_arvalid(t_arvalid[1]), .b_arready(t_arready[1]),
        .b_rid(t_rid[1]), .b_rdata(t_rdata[1]), .b_rresp(t_rresp[1]), .b_rlast(t_rlast[1]),
        .b_rvalid(t_rvalid[1]), .b_rready(t_rready[1]),
        .c_arid(t_arid[2]), .c_araddr(t_araddr[2]), .c_arlen(t_arlen[2]), .c_arextras(t_arextras[2]),
        .c_arburst(t_arburst[2]), .c_arvalid(t_arvalid[2]), .c_arready(t_arready[2]),
        .c_rid(t_rid[2]), .c_rdata(t_rdata[2]), .c_rresp(t_rresp[2]), .c_rlast(t_rlast[2]),
        .c_rvalid(t_rvalid[2]), .c_rready(t_rready[2]),
        .d_arid(t_arid[3]), .d_araddr(t_araddr[3]), .d_arlen(t_arlen[3]), .d_arextras(t_arextras[3]),
        .d_arburst(t_arburst[3]), .d_arvalid(t_arvalid[3]), .d_arready(t_arready[3]),
        .d_rid(t_rid[3]), .d_rdata(t_rdata[3]), .d_rresp(t_rresp[3]), .d_rlast(t_rlast[3]),
        .d_rvalid(t_rvalid[3]), .d_rready(t_rready[3])
    );

    typedef struct {
        logic [IDWID-1:0] id;
        logic [31:0]      addr;
        logic [7:0]       len;
    } ar_t;

    ar_t           tq [4][$];      // bursts each target has accepted
    logic [RW-1:0] exp_q [$];      // expected upstream beats, in order
    int            order_q [$];    // outstanding target indices, in order

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] resp_en = 4'hF;    // per-target permission to return beats
    int         ar_mode = 0;       // 0: arready=1, 1: random, 2: arready=0
    int         rr_mode = 0;       // 0: rready=1, 1: random, 2: toggle

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event never happened within its bound", name);
    endtask

    // Beat content as returned by target k for a given burst.
    function automatic logic [RW-1:0] beat_of(input int k, input logic [IDWID-1:0] id,
                                              input logic [31:0] addr, input int beat, input bit last);
        logic [63:0] d;
        d = {addr, 8'(k), 8'(beat), 12'(id), 4'hA};
        return {id, d, 2'(beat + k), last};
    endfunction

    // ---------------------------------------------------------------- targets
    for (genvar k = 0; k < 4; k++) begin : g_tgt
        initial begin
            int            beat;
            bit            fired;
            ar_t           t;
            logic [RW-1:0] b;
            beat = 0;
            t_arready[k] = 1'b1;
            t_rvalid[k]  = 1'b0;
            t_rid[k] = '0; t_rdata[k] = '0; t_rresp[k] = '0; t_rlast[k] = 1'b0;
            forever begin
                @(negedge clk);
                fired = t_rvalid[k] && t_rready[k];
                @(posedge clk);
                #2;
                if (!rst_n) begin
                    tq[k].delete();
                    beat = 0;
                    t_rvalid[k] = 1'b0;
                end else begin
                    if (fired) begin
                        if (beat == int'(tq[k][0].len)) begin
                            void'(tq[k].pop_front());
                            beat = 0;
                        end else begin
                            beat++;
                        end
                    end
                    case (ar_mode)
                        0:       t_arready[k] = 1'b1;
                        1:       t_arready[k] = ($urandom_range(0, 3) != 0);
                        default: t_arready[k] = 1'b0;
                    endcase
                    if (t_rvalid[k] && !fired) begin
                        // hold the presented beat until it is taken
                    end else if (resp_en[k] && tq[k].size() > 0 && $urandom_range(0, 3) != 0) begin
                        t = tq[k][0];
                        b = beat_of(k, t.id, t.addr, beat, beat == int'(t.len));
                        {t_rid[k], t_rdata[k], t_rresp[k], t_rlast[k]} = b;
                        t_rvalid[k] = 1'b1;
                    end else begin
                        t_rvalid[k] = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------- rready
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       rready = 1'b1;
                1:       rready = 1'($urandom_range(0, 1));
                default: rready = ~rready;
            endcase
        end
    end

    // --------------------------------------------------- monitor / scoreboard
    logic [3:0]    arv_vec, rrv_vec, exp_arv, exp_rrv;
    logic          exp_arready, exp_rvalid;
    logic [1:0]    cur_sel;
    logic [RW-1:0] got_beat;

    always @(negedge clk) begin
        if (rst_n) begin
            arv_vec = {t_arvalid[3], t_arvalid[2], t_arvalid[1], t_arvalid[0]};
            rrv_vec = {t_rready[3],  t_rready[2],  t_rready[1],  t_rready[0]};
            cur_sel = araddr[31:30];

            exp_arv = '0;
            if (arvalid && order_q.size() < DEPTH) exp_arv[cur_sel] = 1'b1;
            exp_arready = t_arready[cur_sel] && (order_q.size() < DEPTH);
            exp_rrv = '0;
            exp_rvalid = 1'b0;
            if (order_q.size() > 0) begin
                exp_rrv[order_q[0]] = rready;
                exp_rvalid = t_rvalid[order_q[0]];
            end
            check("x_arvalid", arv_vec, exp_arv);
            check("arready", arready, exp_arready);
            check("x_rready", rrv_vec, exp_rrv);
            check("rvalid", rvalid, exp_rvalid);
            if (!rvalid) check("r_idle_zero", {rid, rdata, rresp, rlast}, '0);

            for (int k = 0; k < 4; k++) begin
                if (t_arvalid[k] && t_arready[k]) begin
                    tq[k].push_back('{id: t_arid[k], addr: t_araddr[k], len: t_arlen[k]});
                    check("x_ar_payload",
                          {t_arid[k], t_araddr[k], t_arlen[k], t_arextras[k], t_arburst[k]},
                          {arid, araddr, arlen, arextras, arburst});
                end
            end

            if (arvalid && arready) begin
                for (int b = 0; b <= int'(arlen); b++)
                    exp_q.push_back(beat_of(int'(cur_sel), arid, araddr, b, b == int'(arlen)));
                order_q.push_back(int'(cur_sel));
            end

            if (rvalid && rready) begin
                got_beat = {rid, rdata, rresp, rlast};
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL r_unexpected: got beat %0h, expected no beat", got_beat);
                end else begin
                    check("r_beat", got_beat, exp_q.pop_front());
                end
                if (rlast && order_q.size() > 0) void'(order_q.pop_front());
            end
        end
    end

    // ---------------------------------------------------------------- tasks
    task automatic drive_ar(input logic [31:0] addr, input logic [7:0] len);
        @(posedge clk);
        #1;
        arid     = IDWID'($urandom);
        araddr   = addr;
        arlen    = len;
        arextras = EXTRAS'($urandom);
        arburst  = 2'($urandom_range(0, 2));
        arvalid  = 1'b1;
    endtask

    task automatic wait_ar_done();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (arready) break;
            n++;
            if (n > 2000) begin
                fail_now("ar_handshake_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        arvalid = 1'b0;
    endtask

    task automatic issue(input logic [31:0] addr, input logic [7:0] len);
        drive_ar(addr, len);
        wait_ar_done();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() > 0) fail_now("drain_timeout");
        repeat (3) @(posedge clk);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        arvalid = 1'b0;
        exp_q.delete();
        order_q.delete();
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] addr_for(input int t);
        return {2'(t), 30'($urandom)};
    endfunction

    // ---------------------------------------------------------------- stimulus
    initial begin
        do_reset(2);
        @(negedge clk);
        check("reset_rvalid", rvalid, 1'b0);
        check("reset_rready", {t_rready[3], t_rready[2], t_rready[1], t_rready[0]}, 4'b0);

        // single burst to b
        resp_en = 4'hF; ar_mode = 0; rr_mode = 0;
        drive_ar(32'h4000_0000, 8'd3);
        @(negedge clk);
        check("single_b_arvalid", {t_arvalid[3], t_arvalid[2], t_arvalid[1], t_arvalid[0]}, 4'b0010);
        wait_ar_done();
        drain();

        // out-of-order target responses c, a, d answered d, a, c
        resp_en = 4'h0;
        issue(32'h8000_0000, 8'd2);
        issue(32'h0000_1000, 8'd1);
        issue(32'hC000_2000, 8'd3);
        resp_en[3] = 1'b1;
        repeat (10) @(posedge clk);
        resp_en[0] = 1'b1;
        repeat (10) @(posedge clk);
        resp_en[2] = 1'b1;
        drain();

        // fill to DEPTH, then a ninth AR must wait for the first pop
        resp_en = 4'h0;
        for (int i = 0; i < DEPTH; i++) issue(addr_for(i % 4), 8'($urandom_range(0, 3)));
        drive_ar(addr_for(2), 8'd0);
        @(negedge clk);
        check("full_arready", arready, 1'b0);
        check("full_arvalid", {t_arvalid[3], t_arvalid[2], t_arvalid[1], t_arvalid[0]}, 4'b0);
        resp_en = 4'hF;
        wait_ar_done();
        drain();

        // rready toggling mid-burst on port a
        rr_mode = 2;
        issue(addr_for(0), 8'd7);
        drain();
        rr_mode = 0;

        // hold five outstanding, then push while popping
        resp_en = 4'h0;
        for (int i = 0; i < 5; i++) issue(addr_for($urandom_range(0, 3)), 8'd0);
        resp_en = 4'hF;
        for (int i = 0; i < 6; i++) issue(addr_for($urandom_range(0, 3)), 8'($urandom_range(0, 1)));
        drain();

        // pointer wrap: 20 single-beat bursts alternating ports
        ar_mode = 1; rr_mode = 1;
        for (int i = 0; i < 20; i++) issue(addr_for(i % 4), 8'd0);
        drain();

        // random traffic
        for (int i = 0; i < 80; i++) issue(addr_for($urandom_range(0, 3)), 8'($urandom_range(0, 4)));
        drain();

        // reset with three bursts outstanding
        ar_mode = 0; rr_mode = 0; resp_en = 4'h0;
        for (int i = 0; i < 3; i++) issue(addr_for(i + 1), 8'd2);
        do_reset(1);
        @(negedge clk);
        check("post_reset_rvalid", rvalid, 1'b0);
        @(posedge clk);
        #1;
        araddr  = 32'h8000_0000;
        ar_mode = 2;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("post_reset_arready_lo", arready, 1'b0);
        ar_mode = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("post_reset_arready_hi", arready, 1'b1);

        // traffic after reset must not see stale responses
        resp_en = 4'hF; ar_mode = 1; rr_mode = 1;
        for (int i = 0; i < 16; i++) issue(addr_for($urandom_range(0, 3)), 8'($urandom_range(0, 3)));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
